// File: rtl/dcache_ctrl_pkg.sv
// dcache_ctrl_pkg
// Shared definitions for the direct-mapped data cache:
//   - cacheState_t : controller FSM state encoding
//   - WORD_BITS, BYTE_OFF_BITS : fixed word geometry
//   - DEF_NLINES, DEF_WORDS    : default cache geometry
//   - lineBits / wordSelBits / indexBits / tagBits : address-field and
//     line widths derived from the geometry parameters
package dcache_ctrl_pkg;

    localparam int WORD_BITS     = 32;
    localparam int BYTE_OFF_BITS = 2;
    localparam int DEF_NLINES    = 4;
    localparam int DEF_WORDS     = 4;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        REFILL    = 2'd2
    } cacheState_t;

    function automatic int lineBits(input int words);
        return WORD_BITS * words;
    endfunction

    function automatic int wordSelBits(input int words);
        return $clog2(words);
    endfunction

    function automatic int indexBits(input int nlines);
        return $clog2(nlines);
    endfunction

    // Everything above byte offset, word select and index is tag.
    function automatic int tagBits(input int nlines, input int words);
        return WORD_BITS - BYTE_OFF_BITS - $clog2(words) - $clog2(nlines);
    endfunction

endpackage

// File: rtl/dcache_ctrl_if.sv
// dcache_ctrl_if
// Line-granular memory bus between the cache (master) and backing memory
// (slave).
//   mem_req   : transaction request, held until the mem_ready cycle
//   mem_we    : 1 = line writeback, 0 = line refill
//   mem_addr  : line-aligned byte address
//   mem_wdata : writeback line data
//   mem_rdata : refill line data, valid in the mem_ready cycle
//   mem_ready : one-cycle completion pulse
interface dcache_ctrl_if import dcache_ctrl_pkg::*; #(
    parameter int WORDS = DEF_WORDS
) ();

    localparam int LB = lineBits(WORDS);

    logic          mem_req;
    logic          mem_we;
    logic [31:0]   mem_addr;
    logic [LB-1:0] mem_wdata;
    logic [LB-1:0] mem_rdata;
    logic          mem_ready;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );

endinterface

// File: rtl/dcache_array.sv
// dcache_array
// Tag / valid / dirty / data storage for a direct-mapped cache.
//   index            : line selected for read and write
//   rdTag/rdValid/rdDirty/rdLine : combinational read of that line
//   wordWe, byteWe   : CPU store into one word, or one byte lane if byteWe
//   wordSel, byteSel : word and byte lane within the line
//   wdata            : store data (byte stores use wdata[7:0])
//   lineWe           : full-line refill; sets tag, valid=1, dirty=0
// Valid and dirty clear on reset; tag and data contents do not.
module dcache_array import dcache_ctrl_pkg::*; #(
    parameter  int NLINES = DEF_NLINES,
    parameter  int WORDS  = DEF_WORDS,
    localparam int IB = indexBits(NLINES),
    localparam int WB = wordSelBits(WORDS),
    localparam int TB = tagBits(NLINES, WORDS),
    localparam int LB = lineBits(WORDS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [IB-1:0] index,
    output logic [TB-1:0] rdTag,
    output logic          rdValid,
    output logic          rdDirty,
    output logic [LB-1:0] rdLine,
    input  logic          wordWe,
    input  logic          byteWe,
    input  logic [WB-1:0] wordSel,
    input  logic [1:0]    byteSel,
    input  logic [31:0]   wdata,
    input  logic          lineWe,
    input  logic [TB-1:0] lineTag,
    input  logic [LB-1:0] lineData
);

    logic [TB-1:0]     tagMem  [NLINES];
    logic [LB-1:0]     dataMem [NLINES];
    logic [NLINES-1:0] validBits;
    logic [NLINES-1:0] dirtyBits;

    assign rdTag   = tagMem[index];
    assign rdLine  = dataMem[index];
    assign rdValid = validBits[index];
    assign rdDirty = dirtyBits[index];

    // NOTE: non-blocking assignments for every flop, so all state updates at the edge together.
    always_ff @(posedge clk) begin
        if (!reset) begin
            validBits <= '0;
            dirtyBits <= '0;
        end else if (lineWe) begin
            validBits[index] <= 1'b1;
            dirtyBits[index] <= 1'b0;
        end else if (wordWe) begin
            dirtyBits[index] <= 1'b1;
        end
    end

    // NOTE: tag/data arrays have no reset; the valid bits alone guard them, which keeps them RAM-mappable.
    always_ff @(posedge clk) begin
        if (lineWe) begin
            tagMem[index]  <= lineTag;
            dataMem[index] <= lineData;
        end else if (wordWe) begin
            if (byteWe)
                dataMem[index][{wordSel, byteSel, 3'b000} +: 8] <= wdata[7:0];
            else
                dataMem[index][{wordSel, 5'b00000} +: 32] <= wdata;
        end
    end

endmodule

// File: rtl/dcache_ctrl.sv
// dcache_ctrl
// Direct-mapped, write-back, write-allocate data cache controller.
//   clk, reset          : rising-edge clock, synchronous active-low reset
//   LoadM, MemWriteM    : MEM-stage load / store (both high = store)
//   ByteM               : byte access (1) or word access (0)
//   addr, wdata         : byte address and store data
//   rdata               : load data, valid when dhit=1 with a load
//   dhit                : 0 stalls the pipeline while a miss is serviced
//   mem                 : line bus to backing memory (master side)
// A miss on a dirty line writes the old line back, then refills; the held
// access is re-evaluated in IDLE and hits.
module dcache_ctrl import dcache_ctrl_pkg::*; #(
    parameter int NLINES = DEF_NLINES,
    parameter int WORDS  = DEF_WORDS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        LoadM,
    input  logic        MemWriteM,
    input  logic        ByteM,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        dhit,
    dcache_ctrl_if.master mem
);

    localparam int IB = indexBits(NLINES);
    localparam int WB = wordSelBits(WORDS);
    localparam int TB = tagBits(NLINES, WORDS);
    localparam int LB = lineBits(WORDS);

    cacheState_t state, nextState;

    logic [1:0]    byteSel;
    logic [WB-1:0] wordSel;
    logic [IB-1:0] index;
    logic [TB-1:0] addrTag;

    logic [TB-1:0] rdTag;
    logic          rdValid, rdDirty;
    logic [LB-1:0] rdLine;
    logic          wordWe, lineWe;
    logic          access, hit;
    logic [31:0]   rdWord;
    logic [7:0]    rdByte;

    assign byteSel = addr[1:0];
    assign wordSel = addr[BYTE_OFF_BITS +: WB];
    assign index   = addr[BYTE_OFF_BITS + WB +: IB];
    assign addrTag = addr[31 -: TB];

    dcache_array #(
        .NLINES (NLINES),
        .WORDS  (WORDS)
    ) u_array (
        .clk      (clk),
        .reset    (reset),
        .index    (index),
        .rdTag    (rdTag),
        .rdValid  (rdValid),
        .rdDirty  (rdDirty),
        .rdLine   (rdLine),
        .wordWe   (wordWe),
        .byteWe   (ByteM),
        .wordSel  (wordSel),
        .byteSel  (byteSel),
        .wdata    (wdata),
        .lineWe   (lineWe),
        .lineTag  (addrTag),
        .lineData (mem.mem_rdata)
    );

    assign access = LoadM | MemWriteM;
    assign hit    = access && rdValid && (rdTag == addrTag);

    // Byte loads are sign-extended; word loads ignore addr[1:0].
    assign rdWord = rdLine[{wordSel, 5'b00000} +: 32];
    assign rdByte = rdWord[{byteSel, 3'b000} +: 8];
    assign rdata  = ByteM ? {{24{rdByte[7]}}, rdByte} : rdWord;

    // Only a writeback consumes this; the resident line is what gets evicted.
    assign mem.mem_wdata = rdLine;

    always_ff @(posedge clk) begin
        if (!reset)
            state <= IDLE;
        else
            state <= nextState;
    end

    always_comb begin
        // NOTE: every output gets its default first, so no branch can leave a latch behind.
        nextState    = state;
        dhit         = 1'b1;
        mem.mem_req  = 1'b0;
        mem.mem_we   = 1'b0;
        mem.mem_addr = {addrTag, index, {(WB + BYTE_OFF_BITS){1'b0}}};
        wordWe       = 1'b0;
        lineWe       = 1'b0;

        case (state)
            IDLE: begin
                if (access) begin
                    if (hit) begin
                        wordWe = MemWriteM;
                    end else begin
                        dhit      = 1'b0;
                        nextState = (rdValid && rdDirty) ? WRITEBACK : REFILL;
                    end
                end
            end
            WRITEBACK: begin
                dhit         = 1'b0;
                mem.mem_req  = 1'b1;
                mem.mem_we   = 1'b1;
                mem.mem_addr = {rdTag, index, {(WB + BYTE_OFF_BITS){1'b0}}};
                if (mem.mem_ready)
                    nextState = REFILL;
            end
            REFILL: begin
                dhit        = 1'b0;
                mem.mem_req = 1'b1;
                if (mem.mem_ready) begin
                    lineWe    = 1'b1;
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase

        // While reset is held the cache looks idle and writes nothing.
        if (!reset) begin
            nextState   = IDLE;
            dhit        = 1'b1;
            mem.mem_req = 1'b0;
            mem.mem_we  = 1'b0;
            wordWe      = 1'b0;
            lineWe      = 1'b0;
        end
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl
// Directed bench for dcache_ctrl (4 lines x 4 words). A memory responder
// answers line requests after memLat cycles. A behavioural cache model
// (line arrays plus a queue of outstanding memory transactions) predicts
// dhit / mem_* / rdata every cycle; directed vectors add hand-computed
// literal expectations.
module tb_dcache_ctrl;
    import dcache_ctrl_pkg::*;

    localparam int NL = 4;
    localparam int WD = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        LoadM = 1'b0, MemWriteM = 1'b0, ByteM = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic [31:0] rdata;
    logic        dhit;

    dcache_ctrl_if #(.WORDS(WD)) mem ();

    dcache_ctrl #(.NLINES(NL), .WORDS(WD)) dut (
        .clk       (clk),
        .reset     (reset),
        .LoadM     (LoadM),
        .MemWriteM (MemWriteM),
        .ByteM     (ByteM),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .dhit      (dhit),
        .mem       (mem)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Initial memory image; line 0x40 word0 is pinned for the cold-load case.
    function automatic logic [31:0] initWord(input logic [31:0] a);
        if (a == 32'h40) return 32'h12345678;
        return {a[15:0] ^ 16'hC0DE, a[15:0]};
    endfunction

    function automatic logic [127:0] initLine(input logic [31:0] la);
        logic [127:0] l;
        for (int w = 0; w < WD; w++) l[w*32 +: 32] = initWord(la + 32'(w * 4));
        return l;
    endfunction

    // ---------------- memory responder ----------------
    logic [127:0] backing [logic [31:0]];
    int  memLat = 3;
    int  cnt = 0;
    bit  spuriousReady = 0;

    initial begin
        mem.mem_ready = 1'b0;
        mem.mem_rdata = '0;
    end

    always begin
        @(posedge clk);
        #1;
        if (mem.mem_req === 1'b1) begin
            cnt = (mem.mem_ready === 1'b1) ? 1 : cnt + 1;
            if (cnt == memLat) begin
                mem.mem_ready = 1'b1;
                if (mem.mem_we === 1'b1)
                    backing[mem.mem_addr] = mem.mem_wdata;
                else
                    mem.mem_rdata = backing.exists(mem.mem_addr) ? backing[mem.mem_addr]
                                                                 : initLine(mem.mem_addr);
            end else begin
                mem.mem_ready = 1'b0;
            end
        end else begin
            cnt = 0;
            mem.mem_ready = spuriousReady;
            mem.mem_rdata = {4{32'hBAD0BAD0}};
        end
    end

    // ---------------- behavioural model ----------------
    typedef struct {
        bit           we;
        logic [31:0]  a;
        logic [127:0] d;
    } txn_t;

    logic [127:0] mMem [logic [31:0]];
    bit           mValid [NL];
    bit           mDirty [NL];
    logic [31:0]  mTag   [NL];
    logic [127:0] mData  [NL];
    txn_t         q[$];

    function automatic logic [127:0] mLine(input logic [31:0] la);
        return mMem.exists(la) ? mMem[la] : initLine(la);
    endfunction

    int           idx, wsel, bsel;
    logic [31:0]  tg, la, w32;
    logic [7:0]   b8;
    bit           acc, mhit;
    txn_t         t;

    always begin
        @(negedge clk);
        idx  = int'((addr >> 4) % NL);
        wsel = int'((addr >> 2) % WD);
        bsel = int'(addr % 4);
        tg   = addr >> 6;
        acc  = LoadM || MemWriteM;
        mhit = acc && mValid[idx] && (mTag[idx] == tg);
        if (!reset) begin
            check("m_rst_dhit", dhit, 1'b1);
            check("m_rst_req", mem.mem_req, 1'b0);
            check("m_rst_we", mem.mem_we, 1'b0);
        end else if (q.size() != 0) begin
            check("m_busy_dhit", dhit, 1'b0);
            check("m_busy_req", mem.mem_req, 1'b1);
            check("m_busy_we", mem.mem_we, q[0].we);
            check("m_busy_addr", mem.mem_addr, q[0].a);
            if (q[0].we) check("m_wb_data", mem.mem_wdata, q[0].d);
        end else begin
            check("m_idle_dhit", dhit, !acc || mhit);
            check("m_idle_req", mem.mem_req, 1'b0);
            if (mhit && LoadM && !MemWriteM) begin
                w32 = mData[idx][wsel*32 +: 32];
                b8  = w32[bsel*8 +: 8];
                check("m_rdata", rdata, ByteM ? {{24{b8[7]}}, b8} : w32);
            end
        end

        @(posedge clk);
        idx  = int'((addr >> 4) % NL);
        wsel = int'((addr >> 2) % WD);
        bsel = int'(addr % 4);
        tg   = addr >> 6;
        la   = addr & ~32'h3F;
        acc  = LoadM || MemWriteM;
        mhit = acc && mValid[idx] && (mTag[idx] == tg);
        if (!reset) begin
            for (int i = 0; i < NL; i++) begin
                mValid[i] = 0;
                mDirty[i] = 0;
            end
            q.delete();
        end else if (q.size() != 0) begin
            if (mem.mem_ready === 1'b1) begin
                t = q.pop_front();
                if (t.we) begin
                    mMem[t.a] = t.d;
                end else begin
                    mData[idx]  = mLine(t.a);
                    mTag[idx]   = tg;
                    mValid[idx] = 1;
                    mDirty[idx] = 0;
                end
            end
        end else if (acc) begin
            if (mhit) begin
                if (MemWriteM) begin
                    if (ByteM) mData[idx][wsel*32 + bsel*8 +: 8] = wdata[7:0];
                    else       mData[idx][wsel*32 +: 32] = wdata;
                    mDirty[idx] = 1;
                end
            end else begin
                if (mValid[idx] && mDirty[idx])
                    q.push_back('{we: 1'b1, a: (mTag[idx] << 6) | 32'(idx << 4), d: mData[idx]});
                q.push_back('{we: 1'b0, a: la, d: '0});
            end
        end
    end

    // ---------------- directed stimulus ----------------
    bit           sawWb;
    logic [31:0]  wbAddr;
    logic [127:0] wbData;

    task automatic doAccess(input bit ld, input bit st, input bit bt,
                            input logic [31:0] a, input logic [31:0] wd,
                            output int stalls, output logic [31:0] rd);
        @(posedge clk);
        #1;
        LoadM = ld; MemWriteM = st; ByteM = bt; addr = a; wdata = wd;
        stalls = 0;
        sawWb  = 0;
        @(negedge clk);
        while (dhit !== 1'b1 && stalls <= 60) begin
            if (mem.mem_req === 1'b1 && mem.mem_we === 1'b1 && !sawWb) begin
                sawWb  = 1;
                wbAddr = mem.mem_addr;
                wbData = mem.mem_wdata;
            end
            stalls++;
            @(negedge clk);
        end
        if (dhit !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL access_timeout: addr %0h still stalled after %0d cycles", a, stalls);
        end
        rd = rdata;
    endtask

    int          st, n;
    logic [31:0] rd;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        @(negedge clk);
        check("reset_dhit", dhit, 1'b1);
        check("reset_mem_req", mem.mem_req, 1'b0);
        check("reset_mem_we", mem.mem_we, 1'b0);
        @(posedge clk);
        #1 reset = 1'b1;

        // cold load: 1 miss cycle + 3 memory cycles
        doAccess(1, 0, 0, 32'h40, 32'h0, st, rd);
        check("cold_stalls", st, 4);
        check("cold_rdata", rd, 32'h12345678);

        // store hit and readback
        doAccess(0, 1, 0, 32'h44, 32'hDEADBEEF, st, rd);
        check("sw_hit_stalls", st, 0);
        doAccess(1, 0, 0, 32'h44, 32'h0, st, rd);
        check("lw_after_sw", rd, 32'hDEADBEEF);

        // byte store lane 2, upper wdata bits must be ignored
        doAccess(0, 1, 1, 32'h46, 32'hAAAAAA80, st, rd);
        check("sb_hit_stalls", st, 0);
        doAccess(1, 0, 1, 32'h46, 32'h0, st, rd);
        check("lb_neg", rd, 32'hFFFFFF80);
        doAccess(1, 0, 0, 32'h44, 32'h0, st, rd);
        check("lw_lane2_only", rd, 32'hDE80BEEF);
        doAccess(1, 0, 1, 32'h45, 32'h0, st, rd);
        check("lb_lane1", rd, 32'hFFFFFFBE);
        doAccess(1, 0, 1, 32'h4B, 32'h0, st, rd);
        check("lb_lane3", rd, 32'hFFFFFFC0);
        doAccess(1, 0, 1, 32'h48, 32'h0, st, rd);
        check("lb_pos", rd, 32'h00000048);

        // LoadM and MemWriteM together act as a store
        doAccess(1, 1, 0, 32'h4C, 32'hCAFEF00D, st, rd);
        check("ldst_stalls", st, 0);
        doAccess(1, 0, 0, 32'h4C, 32'h0, st, rd);
        check("ldst_readback", rd, 32'hCAFEF00D);

        // dirty eviction: index 0, tag 1 -> tag 5
        doAccess(1, 0, 0, 32'h140, 32'h0, st, rd);
        check("evict_stalls", st, 7);
        check("evict_saw_wb", sawWb, 1'b1);
        check("evict_wb_addr", wbAddr, 32'h40);
        check("evict_wb_word1", wbData[63:32], 32'hDE80BEEF);
        check("evict_wb_word3", wbData[127:96], 32'hCAFEF00D);
        check("evict_rdata", rd, 32'hC19E0140);

        // written-back line returns from memory on a clean-victim refill
        doAccess(1, 0, 0, 32'h44, 32'h0, st, rd);
        check("reload_stalls", st, 4);
        check("reload_rdata", rd, 32'hDE80BEEF);

        // reset in the middle of a refill
        @(posedge clk);
        #1;
        LoadM = 1'b1; MemWriteM = 1'b0; ByteM = 1'b0; addr = 32'hC4;
        n = 0;
        @(negedge clk);
        while (mem.mem_req !== 1'b1 && n < 20) begin
            n++;
            @(negedge clk);
        end
        check("rst_mid_req_seen", mem.mem_req, 1'b1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        LoadM = 1'b0;
        @(negedge clk);
        check("rst_mid_dhit", dhit, 1'b1);
        spuriousReady = 1;
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("rst_after_req", mem.mem_req, 1'b0);
        check("rst_after_dhit", dhit, 1'b1);
        spuriousReady = 0;

        // line 0x40 was resident before reset; it must miss now
        doAccess(1, 0, 0, 32'h44, 32'h0, st, rd);
        check("post_rst_miss", st, 4);
        check("post_rst_rdata", rd, 32'hDE80BEEF);

        // idle pipeline with stray mem_ready pulses
        @(posedge clk);
        #1;
        LoadM = 1'b0; MemWriteM = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            spuriousReady = (i != 1);
            check("idle_dhit", dhit, 1'b1);
            check("idle_req", mem.mem_req, 1'b0);
        end
        @(negedge clk);
        spuriousReady = 0;
        doAccess(1, 0, 0, 32'h44, 32'h0, st, rd);
        check("idle_then_hit", st, 0);
        check("idle_then_rdata", rd, 32'hDE80BEEF);

        @(posedge clk);
        #1 LoadM = 1'b0;
        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
